// File: rtl/life_pkg.sv
// life_pkg: shared states and grid geometry for the life frame sequencer
package life_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, HOLD, ADVANCE} state_t;
  localparam int GRID_CELLS = 64;
  localparam int PIXEL_W = $clog2(GRID_CELLS);
  localparam logic [PIXEL_W-1:0] LAST_PIXEL = 6'd63;
endpackage

// File: rtl/life_hold_timer.sv
// life_hold_timer: latches the hold period (0 clamped to 1) and counts hold cycles
module life_hold_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                expire
);
  logic [PERIOD_W-1:0] eff_m1;
  logic [PERIOD_W-1:0] timer;
  assign expire = run && timer == eff_m1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      eff_m1 <= '0;
      timer  <= '0;
    end else if (clear) begin
      eff_m1 <= period == '0 ? '0 : period - PERIOD_W'(1);
      timer  <= '0;
    end else if (run) begin
      timer  <= timer + PERIOD_W'(1);
    end
endmodule

// File: rtl/life_frame_sequencer.sv
// life_frame_sequencer: scans the 8x8 grid out as a stream, holds, then pulses newframe
module life_frame_sequencer
  import life_pkg::*;
#(
  parameter int PERIOD_W = 24,
  parameter int GEN_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                step,
  input  logic [PERIOD_W-1:0] period,
  output logic                newframe,
  output logic [PIXEL_W-1:0]  pixel,
  input  logic [7:0]          pix_data_in,
  output logic                out_valid,
  output logic [7:0]          out_data,
  output logic [PIXEL_W-1:0]  out_index,
  input  logic                out_ready,
  output logic                frame_done,
  output logic                busy,
  output logic [GEN_W-1:0]    gen_count
);
  state_t state;
  logic   accept;
  logic   last_accept;
  logic   expire;
  assign accept      = out_valid && out_ready;
  assign last_accept = accept && pixel == LAST_PIXEL;
  assign out_data    = pix_data_in;
  assign out_index   = pixel;
  assign busy        = state == SCAN || state == ADVANCE;
  life_hold_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (last_accept),
    .run    (state == HOLD && enable),
    .period (period),
    .expire (expire)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      newframe   <= 1'b0;
      pixel      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      gen_count  <= '0;
    end else begin
      newframe   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE:
          if (enable || step) begin
            state     <= SCAN;
            out_valid <= 1'b1;
            pixel     <= '0;
          end
        SCAN:
          if (accept) begin
            pixel <= pixel + PIXEL_W'(1);
            if (last_accept) begin
              state      <= HOLD;
              out_valid  <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        HOLD:
          if (step || expire) begin
            state    <= ADVANCE;
            newframe <= 1'b1;
          end
        ADVANCE: begin
          state     <= SCAN;
          out_valid <= 1'b1;
          pixel     <= '0;
          gen_count <= gen_count + GEN_W'(1);
        end
      endcase
    end
endmodule
